// File: rtl/fft_out_serializer.sv
// fft_out_serializer: buffers wide FFT result words and emits them as indexed OUT_LANES-wide valid/ready beats.
module fft_out_serializer #(
    parameter int LANES     = 16,
    parameter int OUT_LANES = 4,
    parameter int W         = 13,
    parameter int FRAME     = 512,
    parameter int DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          valid_in,
    input  logic [LANES*W-1:0]            din_re_t,
    input  logic [LANES*W-1:0]            din_im_t,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [OUT_LANES*W-1:0]        dout_re,
    output logic [OUT_LANES*W-1:0]        dout_im,
    output logic [$clog2(FRAME)-1:0]      dout_idx,
    output logic                          dout_last,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          overflow
);
    localparam int B  = LANES / OUT_LANES;
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(FRAME);
    localparam int SW = B > 1 ? $clog2(B) : 1;

    if (LANES % OUT_LANES != 0 || (B & (B - 1)) != 0 || (FRAME & (FRAME - 1)) != 0 ||
        FRAME % LANES != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
        $error("fft_out_serializer: unsupported parameter set");
    end

    logic [LANES*W-1:0] mem_re [DEPTH];
    logic [LANES*W-1:0] mem_im [DEPTH];
    logic [LANES*W-1:0] head_re, head_im;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [SW-1:0]      sel;
    logic               beat, pop, push, full;

    assign full       = level == (AW+1)'(DEPTH);
    assign dout_valid = level != '0;
    assign beat       = dout_valid && dout_ready;
    assign pop        = beat && sel == SW'(B - 1);
    assign push       = valid_in && (!full || pop);
    assign head_re    = mem_re[rd_ptr];
    assign head_im    = mem_im[rd_ptr];

    // Gate the mux so stale FIFO contents never leak out while empty.
    always_comb begin
        dout_re   = dout_valid ? head_re[sel*(OUT_LANES*W) +: OUT_LANES*W] : '0;
        dout_im   = dout_valid ? head_im[sel*(OUT_LANES*W) +: OUT_LANES*W] : '0;
        dout_last = dout_valid && dout_idx == IW'(FRAME - OUT_LANES);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_re[wr_ptr] <= din_re_t;
            mem_im[wr_ptr] <= din_im_t;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sel      <= '0;
            dout_idx <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (beat) begin
                sel      <= pop ? '0 : sel + SW'(1);
                dout_idx <= dout_idx + IW'(OUT_LANES);
            end
            level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (valid_in && !push)
                overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fft_out_serializer.sv
// tb_fft_out_serializer: directed stimulus with a scoreboard queue checked by a decoupled beat monitor.
module tb_fft_out_serializer;
    localparam int LANES = 16;
    localparam int OL    = 4;
    localparam int W     = 13;
    localparam int FRAME = 512;
    localparam int DEPTH = 4;
    localparam int B     = LANES / OL;

    typedef struct {
        logic [OL*W-1:0] re;
        logic [OL*W-1:0] im;
        logic [8:0]      idx;
        logic            last;
    } beat_t;

    logic               clk = 0;
    logic               rstn = 0;
    logic               valid_in = 0;
    logic [LANES*W-1:0] din_re_t = '0;
    logic [LANES*W-1:0] din_im_t = '0;
    logic               dout_valid;
    logic               dout_ready = 0;
    logic [OL*W-1:0]    dout_re, dout_im;
    logic [8:0]         dout_idx;
    logic               dout_last;
    logic [2:0]         level;
    logic               overflow;

    beat_t q[$];
    int    exp_idx = 0;
    int    n_vec = 0, n_bad = 0;
    int    n_beats = 0, n_lasts = 0;
    bit    hold = 0;
    logic [OL*W-1:0] h_re, h_im;
    logic [8:0]      h_idx;
    logic            h_last;

    fft_out_serializer #(.LANES(LANES), .OUT_LANES(OL), .W(W), .FRAME(FRAME), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in), .din_re_t(din_re_t), .din_im_t(din_im_t),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_re(dout_re), .dout_im(dout_im),
        .dout_idx(dout_idx), .dout_last(dout_last), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every transfer pops one expected beat; stalled beats must hold steady.
    always @(negedge clk) begin
        if (!rstn) begin
            hold = 0;
        end else begin
            if (hold) begin
                chk("hold_re", dout_re, h_re);
                chk("hold_im", dout_im, h_im);
                chk("hold_idx", dout_idx, h_idx);
                chk("hold_last", dout_last, h_last);
            end
            hold   = dout_valid && !dout_ready;
            h_re   = dout_re;
            h_im   = dout_im;
            h_idx  = dout_idx;
            h_last = dout_last;
            if (dout_valid && dout_ready) begin
                beat_t e;
                n_beats++;
                if (dout_last) n_lasts++;
                chk("beat_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("beat_re", dout_re, e.re);
                    chk("beat_im", dout_im, e.im);
                    chk("beat_idx", dout_idx, e.idx);
                    chk("beat_last", dout_last, e.last);
                end
            end
        end
    end

    task automatic push_word(input int base, input bit acc);
        beat_t e;
        for (int k = 0; k < LANES; k++) begin
            din_re_t[k*W +: W] = W'(base + k);
            din_im_t[k*W +: W] = W'(-(base + k));
        end
        valid_in = 1;
        if (acc) begin
            for (int b = 0; b < B; b++) begin
                for (int j = 0; j < OL; j++) begin
                    e.re[j*W +: W] = W'(base + b*OL + j);
                    e.im[j*W +: W] = W'(-(base + b*OL + j));
                end
                e.idx  = 9'(exp_idx);
                e.last = exp_idx == FRAME - OL;
                q.push_back(e);
                exp_idx = (exp_idx + OL) % FRAME;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rstn = 0;
        valid_in = 0;
        q.delete();
        exp_idx = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 600 && q.size() != 0; i++) @(posedge clk);
        #1;
        chk(nm, q.size(), 0);
        chk({nm, "_level"}, level, 0);
    endtask

    initial begin
        logic [3:0] pat;
        pat = 4'b1001;
        #3;
        chk("rst_valid", dout_valid, 0);
        chk("rst_idx", dout_idx, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_re", dout_re, 0);
        @(posedge clk); #1 rstn = 1;

        // Single word
        dout_ready = 1;
        push_word(0, 1);
        valid_in = 0;
        chk("single_level1", level, 1);
        chk("single_idx0", dout_idx, 0);
        @(posedge clk); #1;
        chk("single_b1_re", dout_re, {13'd7, 13'd6, 13'd5, 13'd4});
        chk("single_b1_im", dout_im, {-13'sd7, -13'sd6, -13'sd5, -13'sd4});
        chk("single_b1_idx", dout_idx, 4);
        @(posedge clk); #1;
        chk("single_b2_idx", dout_idx, 8);
        @(posedge clk); #1;
        chk("single_b3_idx", dout_idx, 12);
        chk("single_b3_last", dout_last, 0);
        @(posedge clk); #1;
        chk("single_level0", level, 0);
        chk("single_valid0", dout_valid, 0);

        // Backpressure with ready pattern 1,0,0,1
        dout_ready = 0;
        push_word(0, 1);
        valid_in = 0;
        for (int i = 0; i < 16; i++) begin
            dout_ready = pat[3 - (i % 4)];
            @(posedge clk); #1;
        end
        dout_ready = 1;
        drain("bp_drain");

        // Overflow
        dout_ready = 0;
        for (int i = 0; i < 4; i++) push_word(200 + 16*i, 1);
        chk("ovf_level4", level, 4);
        chk("ovf_before", overflow, 0);
        push_word(264, 0);
        valid_in = 0;
        chk("ovf_level_after", level, 4);
        chk("ovf_set", overflow, 1);
        n_beats = 0;
        dout_ready = 1;
        drain("ovf_drain");
        repeat (3) @(posedge clk); #1;
        chk("ovf_beats16", n_beats, 16);
        chk("ovf_sticky", overflow, 1);

        // Frame wrap
        do_reset();
        chk("wrap_rst_overflow", overflow, 0);
        n_beats = 0;
        n_lasts = 0;
        dout_ready = 1;
        for (int i = 0; i < 32; i++) begin
            push_word(16*i, 1);
            valid_in = 0;
            repeat (3) @(posedge clk); #1;
        end
        drain("wrap_drain");
        chk("wrap_beats128", n_beats, 128);
        chk("wrap_lasts1", n_lasts, 1);
        push_word(600, 1);
        valid_in = 0;
        chk("wrap_w33_idx0", dout_idx, 0);
        drain("wrap_w33_drain");

        // Full with simultaneous pop
        do_reset();
        dout_ready = 0;
        for (int i = 0; i < 4; i++) push_word(300 + 16*i, 1);
        valid_in = 0;
        dout_ready = 1;
        repeat (3) @(posedge clk); #1;
        chk("fullpop_full", level, 4);
        push_word(364, 1);
        valid_in = 0;
        chk("fullpop_level", level, 4);
        chk("fullpop_overflow", overflow, 0);
        drain("fullpop_drain");
        chk("fullpop_overflow_end", overflow, 0);

        // Reset mid-operation
        do_reset();
        dout_ready = 0;
        for (int i = 0; i < 3; i++) push_word(400 + 16*i, 1);
        valid_in = 0;
        dout_ready = 1;
        repeat (2) @(posedge clk);
        #1 rstn = 0;
        #1;
        chk("midrst_valid", dout_valid, 0);
        chk("midrst_idx", dout_idx, 0);
        chk("midrst_last", dout_last, 0);
        chk("midrst_level", level, 0);
        chk("midrst_re", dout_re, 0);
        chk("midrst_overflow", overflow, 0);
        q.delete();
        exp_idx = 0;
        @(posedge clk); #1 rstn = 1;
        push_word(500, 1);
        valid_in = 0;
        chk("midrst_new_idx", dout_idx, 0);
        chk("midrst_new_re", dout_re, {13'd503, 13'd502, 13'd501, 13'd500});
        drain("midrst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fft_out_serializer.md
# fft_out_serializer

Parametrised output stage for the parallel FFT core. It accepts one wide multi-lane result word per `valid_in` pulse (the core has no backpressure) and buffers words in a small FIFO. It re-emits them as narrower `OUT_LANES`-wide beats on a valid/ready stream, tagging each beat with its frequency-bin index and an end-of-frame flag. It sits between `top_fft_module` and any downstream consumer or DMA, replacing the fixed 16-lane, no-handshake output.

## Interface
- `LANES`, 16: lanes per input word; must be a multiple of `OUT_LANES`.
- `OUT_LANES`, 4: lanes per output beat; `LANES/OUT_LANES` is a power of 2.
- `W`, 13: signed sample width per lane, real and imaginary separately.
- `FRAME`, 512: FFT points per frame; power of 2 and a multiple of `LANES`.
- `DEPTH`, 4: FIFO depth in full input words; power of 2, at least 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `valid_in` input 1: input word present this cycle.
- `din_re_t` input `LANES*W`: real parts; lane k occupies bits `[k*W+W-1 : k*W]`.
- `din_im_t` input `LANES*W`: imaginary parts, same packing as `din_re_t`.
- `dout_valid` output 1: output beat available.
- `dout_ready` input 1: downstream accepts the beat.
- `dout_re` output `OUT_LANES*W`: real parts of the beat; lane 0 in the LSBs.
- `dout_im` output `OUT_LANES*W`: imaginary parts of the beat.
- `dout_idx` output `clog2(FRAME)`: bin index of lane 0 of the current beat.
- `dout_last` output 1: high on the final beat of a frame.
- `level` output `clog2(DEPTH)+1`: number of occupied FIFO words.
- `overflow` output 1: sticky flag; a word was dropped.

## Operation
- **Definitions:**
  - Beat = one transfer, i.e. a cycle with `dout_valid && dout_ready`.
  - `B = LANES/OUT_LANES` beats per word.
- **Push:**
  - A word is written when `valid_in` is high and the FIFO is not full, or when it is full but a pop occurs in the same cycle.
  - Otherwise the word is dropped and `overflow` is set to 1. `overflow` stays 1 until reset.
- **Output data:**
  - A beat-select counter `sel`, range 0..B-1, picks input lanes `sel*OUT_LANES` to `sel*OUT_LANES+OUT_LANES-1` of the head word.
  - The lanes are passed bit-exact, with no rescaling or sign change.
- **Pop:**
  - On a beat with `sel==B-1`, the head word is popped and `sel` returns to 0.
  - On any other beat, `sel` increments.
- **Index counter:**
  - `dout_idx` advances by `OUT_LANES` on every beat and wraps modulo `FRAME`.
  - `dout_last = dout_valid && (dout_idx == FRAME-OUT_LANES)`.
- **Valid:** `dout_valid = (level != 0)`.
- **Stability:** while `dout_valid && !dout_ready`, all of `dout_re`, `dout_im`, `dout_idx` and `dout_last` hold stable.
- **Simultaneous push and pop:**
  - At full: the push is accepted, the pop frees the slot, and `level` stays at `DEPTH`.
  - At `level==1`: the FIFO never goes empty; `dout_valid` stays 1.
- **Reset:**
  - Asserting `rstn` low at any time clears the FIFO pointers, `sel`, the index counter, `level` and `overflow`.
  - A partially emitted word is discarded. The next accepted word starts at `dout_idx` 0.
- **Out-of-range parameters:** not supported; the design fails elaboration via a generate-time check.

## Timing
- **Reset values:** `dout_valid` 0, `dout_idx` 0, `dout_last` 0, `level` 0, `overflow` 0. `dout_re` and `dout_im` are 0 while `level==0`; the output mux is gated.
- **Latency:** a word written at rising edge t raises `dout_valid` after edge t, so its first beat can transfer in cycle t+1.
- **Throughput:**
  - Sustained input acceptance is 1 word per B cycles with `dout_ready` held high.
  - Bursts of up to `DEPTH` back-to-back words are absorbed without loss.
- **Combinational paths:**
  - `dout_ready` affects only the next-state logic.
  - No combinational path exists from `dout_ready` to `dout_valid` or to the data outputs.
  - `level` and `overflow` are registered.

## Test plan
- **Single word:** defaults, one word with lane k holding re=k and im=-k, `dout_ready`=1.
  - Required: 4 beats with `dout_idx` 0, 4, 8, 12.
  - Beat 1 carries re lanes {4,5,6,7} and im {-4,-5,-6,-7}.
  - `level` goes 1 to 0 after beat 4; `dout_last` stays 0.
- **Backpressure:** toggle `dout_ready` 1,0,0,1,...
  - Required: outputs stay frozen during low cycles.
  - No beat is lost or duplicated; the sequence is identical to the single-word case.
- **Overflow:** `dout_ready`=0, 5 consecutive `valid_in` words.
  - Required: `level`=4, `overflow`=1 from the cycle after word 5.
  - Release ready: exactly 16 beats, holding words 1 to 4 only.
- **Frame wrap:** 32 words of 16 lanes (512 points, matching the cos test vectors), `dout_ready`=1, one word every 4 cycles.
  - Required: 128 beats, with `dout_last`=1 only at `dout_idx`=508.
  - A 33rd word starts at `dout_idx` 0.
- **Full with simultaneous pop:** fill to 4, then on the cycle of the last beat of the head word assert `valid_in`.
  - Required: the word is accepted, `level` stays 4, `overflow` stays 0.
- **Reset mid-operation:** assert `rstn`=0 after beat 2 of a word with 3 words queued.
  - Required: all outputs return to reset values immediately.
  - After release, a new word emits from `dout_idx` 0 with its lanes 0 to 3.
